// File: rtl/dca_matrix_row_packer.sv
// dca_matrix_row_packer
// Packs a stream of W-bit scalars into N*W-bit matrix rows (column 0 in the
// LSBs). It presents each completed row downstream and holds it until the row
// is accepted. A flush pads a partial row with PAD_VALUE and emits it. Rows
// accepted downstream are counted, and matrix_done pulses once every N rows.
module dca_matrix_row_packer #(
    parameter int                          MATRIX_SIZE_PARA = 8,
    parameter int                          BW_TENSOR_SCALAR = 32,
    parameter logic [BW_TENSOR_SCALAR-1:0] PAD_VALUE        = '0,
    localparam int                         BW_TENSOR_ROW    = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR,
    localparam int                         CW               = $clog2(MATRIX_SIZE_PARA)
) (
    input  logic                     clk,
    input  logic                     rstp,
    input  logic                     clear,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BW_TENSOR_SCALAR-1:0] s_data,
    input  logic                     flush,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [BW_TENSOR_ROW-1:0] row_wdata_list1d,
    output logic                     matrix_done,
    output logic [CW-1:0]            col_count,
    output logic [CW-1:0]            row_count
);

    localparam int            N        = MATRIX_SIZE_PARA;
    localparam int            W        = BW_TENSOR_SCALAR;
    localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);

    // FILL gathers scalars into the row buffer; HOLD presents the finished row.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [BW_TENSOR_ROW-1:0] row_q, row_d;
    logic [CW-1:0]            col_q, col_d;
    logic [CW-1:0]            rcnt_q, rcnt_d;
    logic                     done_q, done_d;
    int                       pad_start;

    // State register: clear acts exactly like reset for the following cycle.
    always_ff @(posedge clk) begin
        // NOTE: every flop is written with <= so that all registers update
        // together from the values that were present before the edge.
        if (rstp || clear) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: the row buffer, the column and row counters, and the done pulse.
    always_ff @(posedge clk) begin
        if (rstp || clear) begin
            // NOTE: the row buffer is a plain register, not a RAM. Resetting it to zero
            // gives a known row after reset and drops any partial or held row.
            row_q  <= '0;
            col_q  <= '0;
            rcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            rcnt_q <= rcnt_d;
            done_q <= done_d;
        end
    end

    // Next-state logic: scalar capture, flush padding, and row acceptance.
    always_comb begin
        // NOTE: each variable gets a default before the case statement. A path
        // that leaves a variable unassigned would infer a latch.
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        rcnt_d    = rcnt_q;
        done_d    = 1'b0;
        pad_start = N;

        unique case (state_q)
            FILL: begin
                if (s_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (CW'(i) == col_q) begin
                            row_d[i*W +: W] = s_data;
                        end
                    end
                    if (col_q == IDX_LAST) begin
                        // This scalar completes the row. A coincident flush has nothing to pad.
                        col_d   = '0;
                        state_d = HOLD;
                    end else if (flush) begin
                        // The scalar keeps its column. Padding starts at the next column.
                        pad_start = int'(col_q) + 1;
                        col_d     = '0;
                        state_d   = HOLD;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else if (flush && (col_q != '0)) begin
                    pad_start = int'(col_q);
                    col_d     = '0;
                    state_d   = HOLD;
                end
                for (int i = 0; i < N; i++) begin
                    if (i >= pad_start) begin
                        row_d[i*W +: W] = PAD_VALUE;
                    end
                end
            end
            HOLD: begin
                // The held row stays stable, and flush and s_valid are ignored, until acceptance.
                if (row_ready) begin
                    state_d = FILL;
                    if (rcnt_q == IDX_LAST) begin
                        rcnt_d = '0;
                        done_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Output logic: handshake signals come from the state alone, so neither depends on the other side's valid or ready.
    always_comb begin
        s_ready   = (state_q == FILL);
        row_valid = (state_q == HOLD);
    end

    assign row_wdata_list1d = row_q;
    assign matrix_done      = done_q;
    assign col_count        = col_q;
    assign row_count        = rcnt_q;

endmodule

// File: tb/tb_dca_matrix_row_packer.sv
// Testbench for dca_matrix_row_packer with N=4, W=8, PAD_VALUE=0.
// The drivers push the row each stimulus must produce onto a scoreboard queue.
// A monitor pops and compares one entry on every row handshake.
module tb_dca_matrix_row_packer;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rstp = 1'b1;
    logic           clear = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           flush = 1'b0;
    logic           row_valid;
    logic           row_ready = 1'b0;
    logic [N*W-1:0] row_wdata_list1d;
    logic           matrix_done;
    logic [1:0]     col_count;
    logic [1:0]     row_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    logic [31:0] sb_q[$];

    dca_matrix_row_packer #(
        .MATRIX_SIZE_PARA(N),
        .BW_TENSOR_SCALAR(W),
        .PAD_VALUE(8'h00)
    ) dut (
        .clk(clk),
        .rstp(rstp),
        .clear(clear),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .flush(flush),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .row_wdata_list1d(row_wdata_list1d),
        .matrix_done(matrix_done),
        .col_count(col_count),
        .row_count(row_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: count done pulses, and compare every accepted row against the scoreboard.
    always @(negedge clk) begin
        if (matrix_done === 1'b1) done_cnt++;
        if (rstp === 1'b0 && clear === 1'b0 && row_valid === 1'b1 && row_ready === 1'b1) begin
            hs_cnt++;
            if (sb_q.size() == 0) check("row_unexpected", 32'd1, 32'd0);
            else check("row_data", row_wdata_list1d, sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one scalar, wait (bounded) until it is taken, then drop s_valid and flush.
    task automatic send(input logic [W-1:0] d, input logic fl);
        int k;
        s_valid = 1'b1;
        s_data  = d;
        flush   = fl;
        k = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_row_valid"}, 32'(row_valid), 32'd0);
        check({tag, "_done"}, 32'(matrix_done), 32'd0);
        check({tag, "_col"}, 32'(col_count), 32'd0);
        check({tag, "_rowcnt"}, 32'(row_count), 32'd0);
        check({tag, "_row"}, row_wdata_list1d, 32'd0);
    endtask

    task automatic pulse_reset();
        rstp = 1'b1;
        tick();
        rstp = 1'b0;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int d0;
        int h0;

        // Reset state.
        tick();
        tick();
        rstp = 1'b0;
        check_reset("reset");

        // A single row, latency 1, row_count 1.
        row_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
        sb_q.push_back(32'h04030201);
        check("lat_row_valid", 32'(row_valid), 32'd1);
        check("lat_s_ready", 32'(s_ready), 32'd0);
        tick();
        check("one_row_valid_drop", 32'(row_valid), 32'd0);
        check("one_row_count", 32'(row_count), 32'd1);
        check("one_row_no_done", 32'(matrix_done), 32'd0);

        // A full matrix back to back: done pulse and throughput.
        pulse_reset();
        d0 = done_cnt;
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            send(W'(i), 1'b0);
            if (i % 4 == 3) sb_q.push_back({8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
        end
        tick();
        check("mtx_done_pulse", 32'(matrix_done), 32'd1);
        check("mtx_rowcnt_wrap", 32'(row_count), 32'd0);
        check("mtx_cycles", 32'(cyc - t0), 32'd20);
        tick();
        check("mtx_done_single", 32'(matrix_done), 32'd0);
        check("mtx_done_count", 32'(done_cnt - d0), 32'd1);

        // Backpressure: the row stays stable while s_valid and flush are ignored.
        pulse_reset();
        row_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b0);
        sb_q.push_back(32'hA3A2A1A0);
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_data  = 8'hEE;
            flush   = 1'b1;
            @(negedge clk);
            check("bp_s_ready", 32'(s_ready), 32'd0);
            check("bp_row_valid", 32'(row_valid), 32'd1);
            check("bp_row_stable", row_wdata_list1d, 32'hA3A2A1A0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        flush = 1'b0;
        h0 = hs_cnt;
        row_ready = 1'b1;
        tick();
        check("bp_resume_valid", 32'(row_valid), 32'd0);
        check("bp_resume_ready", 32'(s_ready), 32'd1);
        check("bp_rowcnt", 32'(row_count), 32'd1);
        check("bp_col", 32'(col_count), 32'd0);
        tick();
        tick();
        check("bp_one_handshake", 32'(hs_cnt - h0), 32'd1);

        // Flush variants.
        pulse_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        sb_q.push_back(32'h00CCBBAA);
        check("fl_row_valid", 32'(row_valid), 32'd1);
        check("fl_col", 32'(col_count), 32'd0);
        tick();
        flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fl_col0_no_row", 32'(row_valid), 32'd0);
            check("fl_col0_ready", 32'(s_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        send(8'h11, 1'b0);
        flush = 1'b1;
        sb_q.push_back(32'h00000011);
        tick();
        flush = 1'b0;
        check("fl_alone_valid", 32'(row_valid), 32'd1);
        tick();
        for (int i = 1; i <= 3; i++) send(W'(i), 1'b0);
        send(8'h04, 1'b1);
        sb_q.push_back(32'h04030201);
        check("fl_last_col", 32'(col_count), 32'd0);
        tick();
        check("fl_rowcnt", 32'(row_count), 32'd3);
        check("fl_after_ready", 32'(s_ready), 32'd1);

        // Reset and clear, both in HOLD and in the middle of a row.
        pulse_reset();
        row_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h70 + 8'(i), 1'b0);
        pulse_reset();
        check_reset("rst_hold");
        row_ready = 1'b1;
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_reset("clr_mid");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) send(8'h10 * 8'(r + 1) + 8'(i), 1'b0);
            sb_q.push_back({8'h10 * 8'(r + 1) + 8'd3, 8'h10 * 8'(r + 1) + 8'd2,
                            8'h10 * 8'(r + 1) + 8'd1, 8'h10 * 8'(r + 1)});
        end
        tick();
        check("clr_pre_rowcnt", 32'(row_count), 32'd3);
        row_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h90 + 8'(i), 1'b0);
        d0 = done_cnt;
        row_ready = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_reset("clr_hold");
        tick();
        check("clr_no_done", 32'(done_cnt - d0), 32'd0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        pulse_reset();
        check_reset("rst_mid");
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0);
        sb_q.push_back(32'hC3C2C1C0);
        tick();
        tick();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dca_matrix_row_packer.md
DCA_MATRIX_ROW_PACKER -- requirements
Module: dca_matrix_row_packer

Interface
REQ-001 The block SHALL have parameter MATRIX_SIZE_PARA, default 8, meaning matrix rows = matrix columns = MATRIX_SIZE_PARA (N).
REQ-002 The block SHALL have parameter BW_TENSOR_SCALAR, default 32, meaning scalar width (W); BW_TENSOR_ROW = N*W.
REQ-003 The block SHALL have parameter PAD_VALUE, default 0, meaning the W-bit value for columns filled by flush.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rstp, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port clear, input, 1, synchronous abort of the current matrix.
REQ-007 The block SHALL have port s_valid, input, 1, scalar valid.
REQ-008 The block SHALL have port s_ready, output, 1, scalar ready.
REQ-009 The block SHALL have port s_data, input, W, scalar data.
REQ-010 The block SHALL have port flush, input, 1, pad and emit the current partial row.
REQ-011 The block SHALL have port row_valid, output, 1, packed row available.
REQ-012 The block SHALL have port row_ready, input, 1, downstream accepts the row; drives the matrix register's downmost row write/shift-up.
REQ-013 The block SHALL have port row_wdata_list1d, output, BW_TENSOR_ROW, packed row.
REQ-014 The block SHALL have port matrix_done, output, 1, one-cycle pulse when the Nth row of a matrix is accepted.
REQ-015 The block SHALL have port col_count, output, clog2(N), the next column index being filled.
REQ-016 The block SHALL have port row_count, output, clog2(N), the number of rows accepted in the current matrix.

Function
REQ-017 The block SHALL implement a two-state FSM: FILL (s_ready=1, row_valid=0) and HOLD (s_ready=0, row_valid=1).
REQ-018 In FILL, a scalar SHALL be accepted when s_valid&s_ready and written to row bits [col_count*W +: W], with column 0 at the LSBs.
REQ-019 An accepted scalar SHALL increment col_count, except that acceptance at col_count==N-1 SHALL set col_count to 0 and move the FSM to HOLD.
REQ-020 row_valid SHALL therefore assert the cycle after the last scalar is accepted (latency 1).
REQ-021 In HOLD, row_wdata_list1d SHALL stay stable until row_ready; on row_valid&row_ready the FSM SHALL return to FILL the next cycle.
REQ-022 On row acceptance, row_count SHALL increment, or wrap to 0 when it equals N-1, with matrix_done pulsing for that same single cycle (registered, asserted the cycle after the handshake).
REQ-023 A flush in FILL with col_count>0 SHALL set columns col_count..N-1 to PAD_VALUE, set col_count to 0 and enter HOLD.
REQ-024 When flush coincides with an accepted scalar, the scalar SHALL occupy its column, the padding SHALL start at the following column, and if that scalar completes the row no padding occurs.
REQ-025 A flush in FILL with col_count==0 and no accepted scalar SHALL be ignored.
REQ-026 A flush in HOLD SHALL be ignored.
REQ-027 The block SHALL have no row_valid combinational dependence on row_ready and no s_ready combinational dependence on s_valid.
REQ-028 clear SHALL take priority over every other input and act identically to reset for the next cycle, dropping any buffered row and not pulsing matrix_done.
REQ-029 Back-to-back throughput SHALL be one row per N+1 cycles when row_ready is held high.

Reset
REQ-030 rstp=1 at a clock edge SHALL force FILL, s_ready=1, row_valid=0, matrix_done=0, col_count=0, row_count=0 and the row buffer to all zero, including mid-row or while in HOLD.
REQ-031 After rstp deasserts, the first accepted scalar SHALL go to column 0.

Verification (N=4, W=8, PAD_VALUE=0)
REQ-032 Stream 0x01,0x02,0x03,0x04 with row_ready=1 -> row_valid for 1 cycle the next cycle with row=0x04030201; row_count=1.
REQ-033 Stream 16 scalars 0x00..0x0F with row_ready=1 -> 4 rows 0x03020100..0x0F0E0D0C; matrix_done single pulse after the 4th row; row_count back to 0.
REQ-034 Hold row_ready=0 for 5 cycles after a full row -> s_ready=0, row stable, s_valid ignored; then row_ready=1 -> one handshake, FILL resumes.
REQ-035 Accept 0xAA, 0xBB, then flush together with 0xCC -> row 0x00CCBBAA; flush at col_count=0 -> no row emitted.
REQ-036 Assert rstp (or clear) in HOLD and again after 2 scalars of a row -> all outputs at reset values next cycle; no matrix_done; next row starts at column 0.
